// File: rtl/toy_mips_mc.sv
// Multi-cycle toy MIPS core: FETCH/DECODE/EXEC/MEM/WB FSM with byte-wide program
// load port, start/halt control, sticky illegal trap, retire counter and debug read.
// Latency: ALU 4 cycles, lw/sw 5, branch/j 3, halt 3; no backpressure (self-paced).
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     run pulse, accepted in IDLE/HALT (restarts at pc 0)
//   imem_we/addr/wdata        program byte write, honoured in IDLE/HALT only
//   busy, halted, illegal     status (busy = FETCH..WB, halted = HALT, illegal sticky)
//   pc_out, retired           current pc, completed-instruction count
//   dbg_sel, dbg_data         combinational register-file read (R0 reads 0)
module toy_mips_mc #(
    parameter int XLEN          = 32,
    parameter int IMEM_AW       = 8,
    parameter int DMEM_AW       = 8,
    parameter bit BRANCH_SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_wdata,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [IMEM_AW-1:0] pc_out,
    output logic [31:0]        retired,
    input  logic [4:0]         dbg_sel,
    output logic [XLEN-1:0]    dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BLE  = 6'b000110;
    localparam logic [5:0] OP_BGE  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LI   = 6'b001001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_MOVE = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;

    state_t state, state_nxt;

    logic [7:0]         imem [2**IMEM_AW];
    logic [7:0]         dmem [2**DMEM_AW];
    logic [XLEN-1:0]    regs [32];

    logic [IMEM_AW-1:0] pc;
    logic [31:0]        ir;
    logic [XLEN-1:0]    op_a, op_b, res;
    logic [DMEM_AW-1:0] ea;
    logic [31:0]        retired_q;
    logic               illegal_q;

    // Instruction fields; ir only changes in FETCH so these are stable from DECODE to WB.
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic signed [15:0] imm_s;
    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm_s  = ir[15:0];

    logic [XLEN-1:0] imm_sx;
    assign imm_sx = XLEN'(imm_s);

    logic is_r, is_li, is_addi, is_lw, is_sw, is_bge, is_ble, is_j, is_halt;
    logic r_known, known, br_ge, br_le, br_taken;
    assign is_r    = (opcode == OP_R);
    assign is_li   = (opcode == OP_LI);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_bge  = (opcode == OP_BGE);
    assign is_ble  = (opcode == OP_BLE);
    assign is_j    = (opcode == OP_J);
    assign is_halt = (opcode == OP_HALT);
    assign r_known = (funct == F_SLL) || (funct == F_SRL) || (funct == F_ADD) ||
                     (funct == F_MOVE) || (funct == F_SUB);
    assign known   = (is_r && r_known) || is_li || is_addi || is_lw || is_sw ||
                     is_bge || is_ble || is_j || is_halt;

    assign br_ge    = BRANCH_SIGNED ? ($signed(op_a) >= $signed(op_b)) : (op_a >= op_b);
    assign br_le    = BRANCH_SIGNED ? ($signed(op_a) <= $signed(op_b)) : (op_a <= op_b);
    assign br_taken = is_bge ? br_ge : br_le;

    logic [IMEM_AW-1:0] pc_inc, target;
    assign pc_inc = pc + IMEM_AW'(4);
    assign target = {ir[IMEM_AW-1:2], 2'b00};

    // Shifts by >= XLEN already yield zero with the native shift operators.
    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_LI:   alu_res = imm_sx;
            OP_ADDI: alu_res = op_a + imm_sx;
            OP_R: begin
                case (funct)
                    F_ADD:   alu_res = op_a + op_b;
                    F_SUB:   alu_res = op_a - op_b;
                    F_SLL:   alu_res = op_b << shamt;
                    F_SRL:   alu_res = op_b >> shamt;
                    F_MOVE:  alu_res = op_a;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Little-endian load; each byte address wraps independently.
    logic [XLEN-1:0] load_data;
    always_comb begin
        load_data = '0;
        for (int k = 0; k < XLEN/8; k++) begin
            load_data[8*k +: 8] = dmem[ea + DMEM_AW'(k)];
        end
    end

    logic [31:0] fetch_word;
    assign fetch_word = {imem[pc], imem[pc + IMEM_AW'(1)],
                         imem[pc + IMEM_AW'(2)], imem[pc + IMEM_AW'(3)]};

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (!known || is_halt)   state_nxt = S_HALT;
                else if (is_bge || is_ble || is_j) state_nxt = S_FETCH;
                else if (is_lw || is_sw) state_nxt = S_MEM;
                else                     state_nxt = S_WB;
            end
            S_MEM:   state_nxt = S_WB;
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        case (state)
            S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB: busy = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            ea        <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc        <= '0;
                        retired_q <= '0;
                        illegal_q <= 1'b0;
                    end
                end
                S_FETCH:  ir <= fetch_word;
                S_DECODE: begin
                    op_a <= regs[rs];
                    op_b <= regs[rt];
                end
                S_EXEC: begin
                    res <= alu_res;
                    ea  <= DMEM_AW'(op_a + imm_sx);
                    if (!known) begin
                        illegal_q <= 1'b1;
                    end else if (is_bge || is_ble) begin
                        pc        <= br_taken ? target : pc_inc;
                        retired_q <= retired_q + 32'd1;
                    end else if (is_j) begin
                        pc        <= target;
                        retired_q <= retired_q + 32'd1;
                    end else if (is_halt) begin
                        retired_q <= retired_q + 32'd1;
                    end
                end
                S_MEM: if (is_lw) res <= load_data;
                S_WB: begin
                    pc        <= pc_inc;
                    retired_q <= retired_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Register file; R0 is never written so it always reads zero.
    logic [4:0] wb_idx;
    logic       wb_en;
    assign wb_idx = is_r ? rd : rt;
    assign wb_en  = (is_r || is_li || is_addi || is_lw) && (wb_idx != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == S_WB && wb_en) begin
            regs[wb_idx] <= res;
        end
    end

    // Memories are not reset. A reset asserted mid-instruction forces state to
    // IDLE asynchronously, so a pending MEM-stage store never reaches dmem.
    always_ff @(posedge clk) begin
        if (imem_we && (state == S_IDLE || state == S_HALT)) begin
            imem[imem_addr] <= imem_wdata;
        end
        if (state == S_MEM && is_sw) begin
            for (int k = 0; k < XLEN/8; k++) begin
                dmem[ea + DMEM_AW'(k)] <= op_b[8*k +: 8];
            end
        end
    end

    assign pc_out   = pc;
    assign retired  = retired_q;
    assign illegal  = illegal_q;
    assign dbg_data = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];

endmodule

// File: doc/toy_mips_mc.md
Name: toy_mips_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle toy MIPS core.
- Explicit fetch/decode/execute/memory/writeback FSM.
- Configurable data width, memory depths and branch signedness.
- Host load port for program bytes, start/halt control, illegal-instruction trap, retired-instruction counter and a debug register read port.
- Used as the core for directed program tests in the toy processor environment.

Parameters:
XLEN, 32, datapath/register width in bits; legal values 16 or 32; immediates sign-extended to XLEN.
IMEM_AW, 8, instruction memory address width in bytes; depth 2^IMEM_AW.
DMEM_AW, 8, data memory address width in bytes; depth 2^DMEM_AW.
BRANCH_SIGNED, 1, 1 = bge/ble compare two's-complement; 0 = unsigned.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; accepted only in IDLE or HALT.
imem_we  in  1  program byte write; honoured only in IDLE or HALT.
imem_addr  in  IMEM_AW  program byte address.
imem_wdata  in  8  program byte.
busy  out  1  high in FETCH..WB.
halted  out  1  high in HALT.
illegal  out  1  sticky; set on unknown opcode/funct.
pc_out  out  IMEM_AW  current PC.
retired  out  32  count of completed instructions, wraps.
dbg_sel  in  5  debug register index.
dbg_data  out  XLEN  combinational read of register dbg_sel.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; pc=0; retired=0; illegal=0; busy=0; halted=0.
  - Register file cleared to 0.
  - Memories are not cleared.
  - Reset mid-instruction aborts it with no writeback.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE/HALT + start -> FETCH, with pc=0, illegal=0, retired=0. Registers are kept.
- FETCH (1 cycle): IR <= {imem[pc], imem[pc+1], imem[pc+2], imem[pc+3]}, big-endian; pc+k wraps mod 2^IMEM_AW.
- DECODE (1 cycle):
  - Latch opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], imm[15:0], label[25:0], funct[5:0].
  - Read operands A=R[rs], B=R[rt].
- EXEC (1 cycle):
  - li (001001): result = sext(imm).
  - addi (001000): result = A + sext(imm).
  - R-type (000000), by funct:
    - add 100000: A+B.
    - sub 100010: A-B.
    - sll 000000: B<<shamt; shamt>=XLEN gives 0.
    - srl 000010: B>>shamt, logical.
    - move 100001: A.
    - Instruction word all-zero = nop: no write, goes to WB.
  - lw (100011) / sw (101011): ea = (A + sext(imm)) mod 2^DMEM_AW -> MEM.
  - bge (000111) / ble (000110): compare per BRANCH_SIGNED.
    - Taken: pc = {label[IMEM_AW-1:2], 2'b00}.
    - Not taken: pc = pc+4.
    - Then FETCH; retired++.
  - j (000010): pc = {label[IMEM_AW-1:2], 2'b00}; then FETCH; retired++.
  - halt (111111): state -> HALT; retired++; pc unchanged.
  - Unknown opcode or funct: illegal=1; state -> HALT; no register/memory change; retired unchanged.
- MEM (1 cycle): data memory is little-endian; bytes ea..ea+XLEN/8-1, each address wrapping.
  - sw: writes R[rt] bytes.
  - lw: captures load data.
- WB (1 cycle):
  - Write R[rd] (R-type) or R[rt] (li/addi/lw).
  - Writes to register 0 discarded; R0 always reads 0.
  - pc = pc+4 (wraps); retired++; -> FETCH.
- Latency: ALU ops 4 cycles; lw/sw 5 cycles; branch/j 3 cycles; halt 3 cycles to HALT.
- Debug port: dbg_data reflects the register value after the last WB edge; dbg_sel=0 returns 0.
- imem_we while busy is ignored entirely. start while busy is ignored.
- Simultaneous imem_we and start in IDLE: byte written and start accepted in the same cycle; the fetch one cycle later sees the new byte.

Test Plan:
1. Reset, load "li $1,5; li $2,-3; add $3,$1,$2; halt", start:
   - R3=2, retired=4, halted=1 after 4+4+4+3 = 15 cycles.
2. "li $1,0x00AB; sw $1,4($0); lw $4,4($0); halt":
   - dmem[4]=0xAB, dmem[5..7]=0, R4=0xAB, lw takes 5 cycles.
3. BRANCH_SIGNED=1, R1=-1, R2=1, "bge $1,$2,label" -> not taken, pc+4.
   - With BRANCH_SIGNED=0, same program -> taken to label.
4. Writes to R0:
   - "addi $0,$0,7" -> dbg_sel=0 reads 0, retired increments.
   - Opcode 010101 -> illegal=1, halted=1, retired unchanged.
5. Loop counter: "li $1,0; addi $1,$1,1; ble $1,$5,4" with R5=3 precharged, then halt -> R1=4.
6. Robustness:
   - Assert reset_n low during MEM of sw -> no dmem write, pc=0, state IDLE.
   - imem_we pulsed while busy -> imem unchanged.
